// File: rtl/dcache_assoc.sv
// N-way set-associative write-back/write-allocate data cache between the CPU
// byte port and the 32-bit block memory, with LRU replacement and hit/miss counters.

module dcache_way #(
    parameter int SETS  = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W-1:0] index,
    input  logic             wr_en,
    input  logic [1:0]       offset,
    input  logic [7:0]       wdata,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [31:0]      fill_data,
    output logic             valid,
    output logic             dirty,
    output logic [TAG_W-1:0] tag,
    output logic [31:0]      data
);
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (wr_en) begin
            data_q[index][{offset, 3'b000} +: 8] <= wdata;
        end
    end

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];
endmodule

module dcache_assoc #(
    parameter int WAYS   = 2,
    parameter int SETS   = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    output logic              busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_address,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_busywait,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, MEM_READ, UPDATE} state_t;

    state_t     state_q, state_d;
    logic [WAY_W-1:0] victim_q, vict_way, hit_way;
    logic       refill_pending;

    logic [1:0]       offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] req_tag;
    logic             access, hit, hit_evt, miss_evt;

    logic [WAYS-1:0]            w_valid, w_dirty, w_hit;
    logic [WAYS-1:0][TAG_W-1:0] w_tag;
    logic [WAYS-1:0][31:0]      w_data;
    logic [31:0]                hit_data;

    assign offset  = address[1:0];
    assign index   = address[IDX_W+1:2];
    assign req_tag = address[ADDR_W-1:IDX_W+2];
    assign access  = read | write;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        dcache_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way (
            .CLK      (CLK),
            .RESET    (RESET),
            .index    (index),
            .wr_en    ((state_q == IDLE) && write && w_hit[g] && !RESET),
            .offset   (offset),
            .wdata    (writedata),
            .fill_en  ((state_q == UPDATE) && (victim_q == WAY_W'(g)) && !RESET),
            .fill_tag (req_tag),
            .fill_data(mem_readdata),
            .valid    (w_valid[g]),
            .dirty    (w_dirty[g]),
            .tag      (w_tag[g]),
            .data     (w_data[g])
        );
        assign w_hit[g] = w_valid[g] && (w_tag[g] == req_tag);
    end

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (w_hit[w]) hit_way = WAY_W'(w);
    end

    assign hit      = |w_hit;
    assign hit_data = w_data[hit_way];
    assign readdata = ((state_q == IDLE) && read && hit) ? hit_data[{offset, 3'b000} +: 8] : 8'h00;
    assign hit_evt  = (state_q == IDLE) && access && hit;
    assign miss_evt = (state_q == IDLE) && access && !hit;

    if (WAYS > 1) begin : g_lru
        logic [WAY_W-1:0] age_q [SETS][WAYS];
        logic             found;

        // Prefer an empty way; otherwise evict the oldest (age WAYS-1).
        always_comb begin
            vict_way = '0;
            found    = 1'b0;
            for (int w = 0; w < WAYS; w++)
                if (!w_valid[w] && !found) begin
                    vict_way = WAY_W'(w);
                    found    = 1'b1;
                end
            if (!found)
                for (int w = 0; w < WAYS; w++)
                    if (age_q[index][w] == WAY_W'(WAYS - 1)) vict_way = WAY_W'(w);
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        age_q[s][w] <= WAY_W'(w);
            end else if (hit_evt) begin
                for (int w = 0; w < WAYS; w++)
                    if (WAY_W'(w) == hit_way)
                        age_q[index][w] <= '0;
                    else if (age_q[index][w] < age_q[index][hit_way])
                        age_q[index][w] <= age_q[index][w] + 1'b1;
            end
        end
    end else begin : g_dm
        assign vict_way = '0;
    end

    always_comb begin
        state_d  = state_q;
        busywait = 1'b0;
        case (state_q)
            IDLE: if (access && !hit) begin
                busywait = 1'b1;
                state_d  = (w_valid[vict_way] && w_dirty[vict_way]) ? WRITEBACK : MEM_READ;
            end
            WRITEBACK: begin
                busywait = 1'b1;
                if (!mem_busywait) state_d = MEM_READ;
            end
            MEM_READ: begin
                busywait = 1'b1;
                if (!mem_busywait) state_d = UPDATE;
            end
            UPDATE: begin
                busywait = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_evt) victim_q <= vict_way;
        end
    end

    assign mem_read      = (state_q == MEM_READ);
    assign mem_write     = (state_q == WRITEBACK);
    assign mem_address   = (state_q == WRITEBACK) ? {w_tag[victim_q], index} : {req_tag, index};
    assign mem_writedata = w_data[victim_q];

    // The hit that finishes a refill belongs to the miss, so it is not counted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count      <= '0;
            miss_count     <= '0;
            refill_pending <= 1'b0;
        end else begin
            if (miss_evt) begin
                refill_pending <= 1'b1;
                if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
            end
            if (hit_evt) begin
                refill_pending <= 1'b0;
                if (!refill_pending && hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (2-way, 8 sets, 4-bit counters) with a
// behavioural block memory whose byte at address a holds a (except block 1).

module tb_dcache_assoc;
    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        RESET, read, write, mem_init;
    logic [7:0]  address, writedata, readdata;
    logic        busywait, mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic [3:0]  hit_count, miss_count;

    always #5 CLK = ~CLK;

    dcache_assoc #(.WAYS(2), .SETS(8), .ADDR_W(8), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .busywait(busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
    );

    logic [31:0] mem [64];
    int          mcnt;

    always @(posedge CLK) begin
        if (mem_init) begin
            mcnt <= 0;
            for (int i = 0; i < 64; i++)
                mem[i] <= (i == 1) ? 32'hDDCCBBAA
                        : {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        end else if (mem_read || mem_write) begin
            if (mcnt == LAT) begin
                mcnt <= 0;
                if (mem_write) mem[mem_address] <= mem_writedata;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    assign mem_busywait = (mem_read || mem_write) && (mcnt != LAT);
    assign mem_readdata = mem[mem_address];

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [7:0]  rd;
    int          cyc;
    logic        wb_seen, rd_seen, both_any = 1'b0;
    logic [5:0]  wb_addr, rd_addr;
    logic [31:0] wb_data;

    // One CPU access held until busywait falls; records memory traffic seen on the way.
    task automatic acc(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        read = r; write = w; address = a; writedata = d;
        #1;
        cyc = 0; wb_seen = 1'b0; rd_seen = 1'b0;
        while (busywait && cyc < 100) begin
            @(negedge CLK); #1;
            cyc++;
            if (mem_read && mem_write) both_any = 1'b1;
            if (mem_write && !wb_seen) begin
                wb_seen = 1'b1; wb_addr = mem_address; wb_data = mem_writedata;
            end
            if (mem_read && !rd_seen) begin
                rd_seen = 1'b1; rd_addr = mem_address;
            end
        end
        if (busywait) chk("timeout", 32'(busywait), 32'd0);
        rd = readdata;
        @(posedge CLK); #1;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; mem_init = 1'b1; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0; mem_init = 1'b0;
        #1;
        chk("rst_busy",  32'(busywait),   32'd0);
        chk("rst_mrd",   32'(mem_read),   32'd0);
        chk("rst_mwr",   32'(mem_write),  32'd0);
        chk("rst_rdata", 32'(readdata),   32'h00);
        chk("rst_hits",  32'(hit_count),  32'd0);
        chk("rst_miss",  32'(miss_count), 32'd0);

        // Cold miss, then hit in the same block
        acc(1'b1, 1'b0, 8'h04, 8'h00);
        chk("cold_stall",  32'(cyc > 0),    32'd1);
        chk("cold_rdseen", 32'(rd_seen),    32'd1);
        chk("cold_rdaddr", 32'(rd_addr),    32'h01);
        chk("cold_nowb",   32'(wb_seen),    32'd0);
        chk("cold_data",   32'(rd),         32'hAA);
        chk("cold_miss",   32'(miss_count), 32'd1);
        chk("cold_hits",   32'(hit_count),  32'd0);
        chk("cold_busy",   32'(busywait),   32'd0);
        acc(1'b1, 1'b0, 8'h06, 8'h00);
        chk("hit_nostall", 32'(cyc),        32'd0);
        chk("hit_data",    32'(rd),         32'hCC);
        chk("hit_count1",  32'(hit_count),  32'd1);

        // Set 0: write-allocate, fill second way, LRU victims
        acc(1'b0, 1'b1, 8'h00, 8'h55);
        chk("wa_rdaddr", 32'(rd_addr),    32'h00);
        chk("wa_nowb",   32'(wb_seen),    32'd0);
        chk("wa_miss",   32'(miss_count), 32'd2);
        chk("wa_hits",   32'(hit_count),  32'd1);
        acc(1'b1, 1'b0, 8'h20, 8'h00);
        chk("w1_rdaddr", 32'(rd_addr), 32'h08);
        chk("w1_nowb",   32'(wb_seen), 32'd0);
        chk("w1_data",   32'(rd),      32'h20);
        acc(1'b1, 1'b0, 8'h00, 8'h00);
        chk("wr_hit",    32'(cyc),       32'd0);
        chk("wr_data",   32'(rd),        32'h55);
        chk("wr_hits",   32'(hit_count), 32'd2);
        acc(1'b1, 1'b0, 8'h40, 8'h00);
        chk("lru_rdaddr", 32'(rd_addr), 32'h10);
        chk("lru_nowb",   32'(wb_seen), 32'd0);
        chk("lru_data",   32'(rd),      32'h40);
        acc(1'b1, 1'b0, 8'h00, 8'h00);
        chk("lru_keep",   32'(cyc),     32'd0);
        chk("lru_kdata",  32'(rd),      32'h55);
        acc(1'b1, 1'b0, 8'h20, 8'h00);
        chk("lru_evict",  32'(cyc > 0), 32'd1);
        chk("lru_edata",  32'(rd),      32'h20);

        // Dirty 0x00 line is now oldest: writeback then refill
        acc(1'b1, 1'b0, 8'h40, 8'h00);
        chk("wb_seen",   32'(wb_seen), 32'd1);
        chk("wb_addr",   32'(wb_addr), 32'h00);
        chk("wb_data",   wb_data,      32'h03020155);
        chk("wb_rdaddr", 32'(rd_addr), 32'h10);
        chk("wb_rdata",  32'(rd),      32'h40);
        acc(1'b1, 1'b0, 8'h00, 8'h00);
        chk("wb_reload", 32'(rd),         32'h55);
        chk("wb_miss",   32'(miss_count), 32'd7);
        chk("wb_hits",   32'(hit_count),  32'd3);

        // Read+write together acts as a write
        acc(1'b1, 1'b1, 8'h01, 8'h77);
        chk("rw_hit", 32'(cyc), 32'd0);
        acc(1'b1, 1'b0, 8'h01, 8'h00);
        chk("rw_data", 32'(rd),        32'h77);
        chk("rw_hits", 32'(hit_count), 32'd5);

        // Reset while refilling
        @(negedge CLK);
        read = 1'b1; address = 8'h24;
        #1;
        chk("mr_busy", 32'(busywait), 32'd1);
        @(negedge CLK); #1;
        chk("mr_strobe", 32'(mem_read), 32'd1);
        RESET = 1'b1; read = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK); #1;
        chk("ra_mrd",  32'(mem_read),   32'd0);
        chk("ra_mwr",  32'(mem_write),  32'd0);
        chk("ra_busy", 32'(busywait),   32'd0);
        chk("ra_hits", 32'(hit_count),  32'd0);
        chk("ra_miss", 32'(miss_count), 32'd0);
        acc(1'b1, 1'b0, 8'h00, 8'h00);
        chk("ra_cold",   32'(cyc > 0),    32'd1);
        chk("ra_rdaddr", 32'(rd_addr),    32'h00);
        chk("ra_data",   32'(rd),         32'h55);
        chk("ra_miss1",  32'(miss_count), 32'd1);

        // Hit counter saturation
        for (int i = 0; i < 20; i++) begin
            acc(1'b1, 1'b0, 8'h00, 8'h00);
            if (i == 13) chk("sat_14", 32'(hit_count), 32'hE);
        end
        chk("sat_hits",   32'(hit_count),  32'hF);
        chk("sat_miss",   32'(miss_count), 32'd1);
        chk("strobe_excl", 32'(both_any),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
